// File: rtl/weight_stream_loader_pkg.sv
// Shared definitions for the weight-stream loader: FSM state type, lane/beat
// geometry helpers and the parameter sanity check used at elaboration.
package weight_stream_loader_pkg;

  typedef enum logic [0:0] {
    StLoad,
    StFull
  } ld_state_e;

  // Number of input beats that make up one RAM word.
  function automatic int unsigned beats_per_word(input int unsigned word_lanes,
                                                 input int unsigned parallelism);
    return word_lanes / parallelism;
  endfunction

  // Bit offset of a lane inside a packed word.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned precision);
    return lane * precision;
  endfunction

  // Index width for a counter or array of n entries, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Geometry must tile a word exactly with whole beats, and hold at least one word.
  function automatic bit params_ok(input int unsigned word_lanes, input int unsigned parallelism,
                                   input int unsigned depth);
    return (parallelism != 0) && (word_lanes >= parallelism) &&
           ((word_lanes % parallelism) == 0) && (depth >= 1);
  endfunction

endpackage

// File: rtl/weight_stream_loader_ram.sv
// Simple dual-port buffer RAM: one write port, one ce0-gated two-stage read
// port. Reads colliding with a write to the same word return the old data.
module weight_stream_loader_ram
  import weight_stream_loader_pkg::*;
#(
  parameter int unsigned WIDTH  = 512,
  parameter int unsigned DEPTH  = 72,
  parameter int unsigned AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [AWIDTH-1:0] address0,
  input  logic              ce0,
  output logic [WIDTH-1:0]  q0
);

  localparam int unsigned RamAw = idx_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] s0_q;
  logic [WIDTH-1:0] q0_q;

  // Address MSBs above the array range are don't-care (out-of-range reads are undefined).
  logic unused_addr;
  assign unused_addr = ^{waddr, address0};

  // Write port; storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr[RamAw-1:0]] <= wdata;
    end
  end

  // Two-stage read pipeline, both stages frozen while ce0 is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q <= '0;
      q0_q <= '0;
    end else if (ce0) begin
      s0_q <= mem[address0[RamAw-1:0]];
      q0_q <= s0_q;
    end
  end

  assign q0 = q0_q;

endmodule

// File: rtl/weight_stream_loader.sv
// Receives a valid/ready stream of PARALLELISM-lane beats, packs them into
// WORD_LANES-lane words and fills DEPTH RAM words, then raises loaded. The
// buffer is replayed through a ROM-like registered read port.
module weight_stream_loader
  import weight_stream_loader_pkg::*;
#(
  parameter int unsigned PRECISION   = 16,
  parameter int unsigned PARALLELISM = 4,
  parameter int unsigned WORD_LANES  = 32,
  parameter int unsigned DEPTH       = 72,
  parameter int unsigned AWIDTH      = $clog2(DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PRECISION-1:0]            data_in [PARALLELISM],
  input  logic                            data_in_valid,
  output logic                            data_in_ready,
  input  logic                            reload,
  output logic                            loaded,
  output logic [AWIDTH-1:0]               word_count,
  input  logic [AWIDTH-1:0]               address0,
  input  logic                            ce0,
  output logic [PRECISION*WORD_LANES-1:0] q0
);

  localparam int unsigned BEATS_PER_WORD = beats_per_word(WORD_LANES, PARALLELISM);
  localparam int unsigned BeatW          = idx_width(BEATS_PER_WORD);
  localparam int unsigned WordW          = PRECISION * WORD_LANES;

  if (!params_ok(WORD_LANES, PARALLELISM, DEPTH)) begin : g_param_err
    $error("weight_stream_loader: WORD_LANES must be a multiple of PARALLELISM and DEPTH >= 1");
  end

  ld_state_e        state_q, state_d;
  logic [BeatW-1:0] beat_idx_q, beat_idx_d;
  logic [AWIDTH-1:0] word_count_q, word_count_d;
  logic [WordW-1:0] pack_q, pack_d;
  logic [WordW-1:0] word_wr;
  logic             fire;
  logic             last_beat;
  logic             wr_en;

  // No skid buffer: ready depends only on state, reload and reset.
  assign data_in_ready = (state_q == StLoad) && !reload && !rst;
  assign fire          = data_in_valid && data_in_ready;
  assign last_beat     = (beat_idx_q == BeatW'(BEATS_PER_WORD - 1));
  assign wr_en         = fire && last_beat;
  assign loaded        = (state_q == StFull);
  assign word_count    = word_count_q;

  // Merge the current beat into the held lower beats to form the word being written.
  always_comb begin
    word_wr = pack_q;
    for (int unsigned i = 0; i < PARALLELISM; i++) begin
      word_wr[lane_lsb(32'(beat_idx_q) * PARALLELISM + i, PRECISION) +: PRECISION] = data_in[i];
    end
  end

  // Next-state logic: packing, word counting and LOAD/FULL transitions; reload overrides.
  always_comb begin
    state_d      = state_q;
    beat_idx_d   = beat_idx_q;
    word_count_d = word_count_q;
    pack_d       = pack_q;
    unique case (state_q)
      StLoad: begin
        if (fire) begin
          pack_d = word_wr;
          if (last_beat) begin
            beat_idx_d   = '0;
            word_count_d = word_count_q + AWIDTH'(1);
            if (word_count_q == AWIDTH'(DEPTH - 1)) begin
              state_d = StFull;
            end
          end else begin
            beat_idx_d = beat_idx_q + BeatW'(1);
          end
        end
      end
      StFull: begin
        state_d = StFull;
      end
    endcase
    // Partial word in pack_q needs no clearing: every lane is rewritten before the next write.
    if (reload) begin
      state_d      = StLoad;
      beat_idx_d   = '0;
      word_count_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StLoad;
      beat_idx_q   <= '0;
      word_count_q <= '0;
      pack_q       <= '0;
    end else begin
      state_q      <= state_d;
      beat_idx_q   <= beat_idx_d;
      word_count_q <= word_count_d;
      pack_q       <= pack_d;
    end
  end

  // The completed-word counter doubles as the write address.
  weight_stream_loader_ram #(
    .WIDTH  (WordW),
    .DEPTH  (DEPTH),
    .AWIDTH (AWIDTH)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .we       (wr_en),
    .waddr    (word_count_q),
    .wdata    (word_wr),
    .address0 (address0),
    .ce0      (ce0),
    .q0       (q0)
  );

endmodule
